// File: rtl/pooling_forward_max.sv
// ---------------------------------------------------------------------------
// pooling_forward_max
//   Forward max-pooling unit. Accepts one k_w*k_h window of IEEE-754 single
//   precision bit patterns per handshake, scans it one element per clock and
//   returns the largest element together with its flat index. The index is
//   what the backward pass uses to route the error term.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   in_valid      window on data_vect_in is valid
//   in_ready      block can accept a window this cycle (combinational)
//   data_vect_in  WIDTH x 32-bit elements, element j has flat index j
//   out_valid     max_value / max_flt_idx are valid
//   out_ready     consumer accepts the result
//   max_value     maximum element of the window, bit-exact copy of an input
//   max_flt_idx   flat index of max_value, zero-extended to 8 bits
// ---------------------------------------------------------------------------
module pooling_forward_max #(
  parameter int k_w = 3,
  parameter int k_h = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_vect_in [k_w*k_h-1:0],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] max_value,
  output logic [7:0]  max_flt_idx
);

  localparam int WIDTH = k_w * k_h;
  // Narrowest counter that can address every element (at least one bit).
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_buf [WIDTH-1:0];
  logic [IDX_W-1:0] r_cnt;
  logic [31:0]      r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;

  // Sign-magnitude "a > b" on raw float patterns. Mapping each pattern to a
  // signed integer (+mag or -mag) makes +0 and -0 equal and orders negatives
  // by decreasing magnitude; NaN/Inf fall out as ordinary magnitudes.
  function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] va;
    logic signed [31:0] vb;
    va = a[31] ? -$signed({1'b0, a[30:0]}) : $signed({1'b0, a[30:0]});
    vb = b[31] ? -$signed({1'b0, b[30:0]}) : $signed({1'b0, b[30:0]});
    return va > vb;
  endfunction

  // NOTE: every signal driven here gets a value on every path (default
  // first), so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    if (r_state == IDLE || (r_state == DONE && out_ready)) begin
      in_ready = 1'b1;
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == IDX_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_out_valid <= 1'b0;
      // NOTE: the window buffer is a register bank, not a RAM, so it is
      // cleared with the rest of the state; nothing stale survives a reset.
      for (int i = 0; i < WIDTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      // Covers both the IDLE accept and the back-to-back DONE retire+accept.
      r_buf       <= data_vect_in;
      r_best      <= data_vect_in[0];
      r_best_idx  <= '0;
      r_cnt       <= IDX_W'(1);
      r_state     <= (WIDTH > 1) ? SCAN : DONE;
      r_out_valid <= (WIDTH == 1);
    end else begin
      case (r_state)
        SCAN: begin
          // Strict greater-than keeps the lowest index on ties.
          if (f_gt(r_buf[r_cnt], r_best)) begin
            r_best     <= r_buf[r_cnt];
            r_best_idx <= r_cnt;
          end
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // in_valid is low here, otherwise the accept branch would have won.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The running best is the result register; it only changes while out_valid
  // is low, so the outputs are stable for the whole DONE phase.
  assign out_valid   = r_out_valid;
  assign max_value   = r_best;
  assign max_flt_idx = 8'(r_best_idx);

endmodule
